// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO for the MIPS datapath.
// One shift-add or shift-subtract step per cycle, then a sign-fix cycle.
module mult_div_unit #(
    parameter int unsigned NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [NBits-1:0] A,
    input  logic [NBits-1:0] B,
    input  logic             WriteHI,
    input  logic             WriteLO,
    input  logic [NBits-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [NBits-1:0] HI,
    output logic [NBits-1:0] LO
);

    localparam int unsigned CntW = $clog2(NBits);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 is_div_q;
    logic                 div0_q;
    logic                 res_neg_q;
    logic                 rem_neg_q;
    logic [NBits-1:0]     opnd_q;
    logic [2*NBits-1:0]   acc_q;
    logic [NBits-1:0]     hi_q;
    logic [NBits-1:0]     lo_q;
    logic                 done_q;
    logic                 dbz_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [NBits-1:0]     a_abs;
    logic [NBits-1:0]     b_abs;
    logic [NBits:0]       mul_sum;
    logic [2*NBits-1:0]   mul_next;
    logic [NBits:0]       div_shift;
    logic                 div_ge;
    logic [NBits-1:0]     div_diff;
    logic [NBits-1:0]     div_rem;
    logic [2*NBits-1:0]   div_next;
    logic [2*NBits-1:0]   prod;
    logic [NBits-1:0]     quo;
    logic [NBits-1:0]     rem;
    logic [NBits-1:0]     fix_hi;
    logic [NBits-1:0]     fix_lo;

    // Op[0] set means unsigned, so only signed ops take magnitudes.
    assign a_neg = ~Op[0] & A[NBits-1];
    assign b_neg = ~Op[0] & B[NBits-1];
    assign a_abs = a_neg ? -A : A;
    assign b_abs = b_neg ? -B : B;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*NBits-1:NBits]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[NBits-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient bits}.
    assign div_shift = {acc_q[2*NBits-1:NBits], acc_q[NBits-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[NBits-1:0] - opnd_q;
    assign div_rem   = div_ge ? div_diff : div_shift[NBits-1:0];
    assign div_next  = {div_rem, acc_q[NBits-2:0], div_ge};

    assign prod   = res_neg_q ? -acc_q : acc_q;
    assign quo    = res_neg_q ? -acc_q[NBits-1:0] : acc_q[NBits-1:0];
    assign rem    = rem_neg_q ? -acc_q[2*NBits-1:NBits] : acc_q[2*NBits-1:NBits];
    // A zero divisor leaves the dividend in the remainder, so only LO needs forcing.
    assign fix_hi = is_div_q ? rem : prod[2*NBits-1:NBits];
    assign fix_lo = is_div_q ? (div0_q ? '1 : quo) : prod[NBits-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (WriteHI) hi_q <= WriteData;
                    if (WriteLO) lo_q <= WriteData;
                    if (Start) begin
                        is_div_q  <= Op[1];
                        div0_q    <= Op[1] && (B == '0);
                        res_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        opnd_q    <= Op[1] ? b_abs : a_abs;
                        acc_q     <= {{NBits{1'b0}}, (Op[1] ? a_abs : b_abs)};
                        cnt_q     <= '0;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(NBits - 1)) state_q <= StFix;
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    dbz_q   <= div0_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Busy      = (state_q != StIdle);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random bench for mult_div_unit; expected {DivByZero, HI, LO}
// are queued at issue time and popped when Done pulses.
module tb_mult_div_unit;

    localparam int unsigned N = 32;
    localparam int unsigned Latency = N + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [1:0]   Op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         WriteHI;
    logic         WriteLO;
    logic [N-1:0] WriteData;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [N-1:0] HI;
    logic [N-1:0] LO;

    typedef struct packed {
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mult_div_unit #(.NBits(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .WriteHI   (WriteHI),
        .WriteLO   (WriteLO),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference built on plain integer arithmetic, special cases first.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] x;
        logic [63:0] y;
        int sa;
        int sb_;
        int q;
        int r;
        case (op)
            2'b00: begin
                x = {{32{a[31]}}, a};
                y = {{32{b[31]}}, b};
                return {1'b0, x * y};
            end
            2'b01: begin
                x = {32'h0, a};
                y = {32'h0, b};
                return {1'b0, x * y};
            end
            2'b10: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {1'b0, 32'h0, 32'h8000_0000};
                sa  = $signed(a);
                sb_ = $signed(b);
                q   = sa / sb_;
                r   = sa % sb_;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [64:0] e);
        exp_t t;
        @(negedge clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        t.dbz = e[64];
        t.hi  = e[63:32];
        t.lo  = e[31:0];
        t.sc  = cyc + 1;
        sb.push_back(t);
    endtask

    task automatic issue_model(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        issue(op, a, b, model(op, a, b));
    endtask

    // Operands are scrambled after the Start edge; the running op must not notice.
    task automatic wait_done(input string tag);
        int   n = 0;
        logic got = 1'b0;
        exp_t t;
        while (n < 60 && !got) begin
            @(posedge clk);
            #1;
            Start   = 1'b0;
            WriteHI = 1'b0;
            WriteLO = 1'b0;
            A       = $urandom;
            B       = $urandom;
            Op      = 2'($urandom_range(3, 0));
            n++;
            got = Done;
        end
        check({tag, " done"}, 64'(got), 64'd1);
        if (got && sb.size() > 0) begin
            t = sb.pop_front();
            check({tag, " hi"}, 64'(HI), 64'(t.hi));
            check({tag, " lo"}, 64'(LO), 64'(t.lo));
            check({tag, " dbz"}, 64'(DivByZero), 64'(t.dbz));
            check({tag, " latency"}, 64'(cyc - t.sc + 1), 64'(Latency));
            check({tag, " busy"}, 64'(Busy), 64'd0);
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int dones;
        reset = 1'b0;
        Start = 1'b0;
        Op = 2'b00;
        A = '0;
        B = '0;
        WriteHI = 1'b0;
        WriteLO = 1'b0;
        WriteData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(Busy), 64'd0);
        check("rst done", 64'(Done), 64'd0);
        check("rst dbz", 64'(DivByZero), 64'd0);
        check("rst hi", 64'(HI), 64'd0);
        check("rst lo", 64'(LO), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        wait_done("multu_max");
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        wait_done("mult_neg");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h4000_0000, 32'h0000_0000});
        wait_done("mult_minmin");
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done("div_neg");
        issue(2'b11, 32'h0000_0064, 32'h0000_0007, {1'b0, 32'h0000_0002, 32'h0000_000E});
        wait_done("divu");
        issue(2'b11, 32'h0000_0064, 32'h0000_0000, {1'b1, 32'h0000_0064, 32'hFFFF_FFFF});
        wait_done("divu_zero");
        issue(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, {1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFFF});
        wait_done("div_zero_neg");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000});
        wait_done("div_ovf");

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(300, 1));
            issue_model(2'(i % 4), ra, rb);
            wait_done("rand");
        end

        // Back-to-back: second Start lands in the Done cycle of the first.
        issue_model(2'b10, 32'h0001_2345, 32'hFFFF_FF00);
        wait_done("b2b_first");
        issue_model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done("b2b_second");

        // Start and MTHI while busy are dropped.
        issue(2'b01, 32'h0000_0007, 32'h0000_0009, {1'b0, 32'h0, 32'h0000_003F});
        repeat (5) @(negedge clk);
        Start = 1'b1;
        Op = 2'b10;
        A = 32'h0000_0050;
        B = 32'h0000_0000;
        WriteHI = 1'b1;
        WriteData = 32'hDEAD_BEEF;
        @(negedge clk);
        Start = 1'b0;
        WriteHI = 1'b0;
        wait_done("busy_ignore");
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Done) dones++;
        end
        check("busy_ignore extra done", 64'(dones), 64'd0);
        check("busy_ignore hi held", 64'(HI), 64'd0);

        // MTHI in the Start cycle is visible, then overwritten at FIX.
        issue(2'b11, 32'h0000_0064, 32'h0000_0007, {1'b0, 32'h0000_0002, 32'h0000_000E});
        WriteHI = 1'b1;
        WriteData = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        Start = 1'b0;
        WriteHI = 1'b0;
        check("start_mthi hi", 64'(HI), 64'h0000_ABCD);
        check("start_mthi busy", 64'(Busy), 64'd1);
        wait_done("start_mthi");

        // Reset at RUN edge 10 aborts without writing.
        @(negedge clk);
        Start = 1'b1;
        Op = 2'b01;
        A = 32'h0000_1111;
        B = 32'h0000_2222;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 64'(Busy), 64'd0);
        check("abort hi", 64'(HI), 64'd0);
        check("abort lo", 64'(LO), 64'd0);
        check("abort done", 64'(Done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (Done) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);

        @(negedge clk);
        WriteLO = 1'b1;
        WriteData = 32'h0000_1234;
        @(posedge clk);
        #1;
        WriteLO = 1'b0;
        check("mtlo lo", 64'(LO), 64'h0000_1234);
        check("mtlo hi", 64'(HI), 64'd0);
        @(negedge clk);
        WriteHI = 1'b1;
        WriteData = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        WriteHI = 1'b0;
        check("mthi hi", 64'(HI), 64'hCAFE_0001);
        check("mthi lo", 64'(LO), 64'h0000_1234);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
